branch_redirect_ctrl: RTL and testbench

Fetch-side direction/target predictor plus EX-stage redirect sequencer for the 5-stage RISC-V pipeline. It predicts taken branches/JALs at IF from a small direct-mapped branch target table. It compares the EX-stage resolution (PcSel/BrPC/PC+4 from the branch unit) against the prediction carried down the pipe. On mismatch it issues a registered PC redirect and a one-cycle pipeline flush with wrong-path squash.

---
 rtl/branch_redirect_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// IF-side branch target table predictor plus EX-stage mispredict redirect/flush sequencer.
// Optional macro BP_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_redirect_ctrl #(
    parameter int PC_W    = 9,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_pc,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [PC_W-1:0] ex_pred_pc,
    input  logic            ex_pcsel,
    input  logic [31:0]     ex_brpc,
    input  logic [31:0]     ex_pc_four,
    output logic            redirect,
    output logic [31:0]     redirect_pc,
    output logic            flush
`ifdef BP_STATS_EN
    ,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispredicts
`endif
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    typedef enum logic {RUN, SQUASH} state_t;

    state_t          state_q;
    logic            redirect_q;
    logic            flush_q;
    logic [31:0]     redirect_pc_q;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic [PC_W-1:0]  brpc_lo;
    logic             resolve;
    logic             actual_taken;
    logic             ex_hit;
    logic             mispredict;

    logic             upd_en;
    logic [1:0]       upd_ctr;
    logic [PC_W-1:0]  upd_target;

    logic unused_ok;
    assign unused_ok = ^{if_pc[1:0], ex_pc[1:0]};

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx  = ex_pc[IDX_W+1:2];
    assign ex_tag  = ex_pc[PC_W-1:IDX_W+2];
    assign brpc_lo = ex_brpc[PC_W-1:0];

    // Prediction reads the registered table; a same-cycle update is not bypassed.
    assign pred_taken = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][1];
    assign pred_pc    = pred_taken ? target_q[if_idx] : if_pc + PC_W'(4);

    assign resolve      = (state_q == RUN) && ex_valid;
    assign actual_taken = ex_pcsel;
    assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign mispredict   = resolve && (ex_is_jalr ||
                          (actual_taken && (!ex_pred_taken || (ex_pred_pc != brpc_lo))) ||
                          (!actual_taken && ex_pred_taken));

    always_comb begin
        upd_en     = 1'b0;
        upd_ctr    = ctr_q[ex_idx];
        upd_target = target_q[ex_idx];
        if (resolve && !ex_is_jalr) begin
            if (ex_is_jal) begin
                upd_en     = 1'b1;
                upd_ctr    = 2'd3;
                upd_target = brpc_lo;
            end else if (ex_is_branch) begin
                if (ex_hit && actual_taken) begin
                    upd_en     = 1'b1;
                    upd_ctr    = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
                    upd_target = brpc_lo;
                end else if (ex_hit) begin
                    upd_en  = 1'b1;
                    upd_ctr = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
                end else if (actual_taken) begin
                    upd_en     = 1'b1;
                    upd_ctr    = 2'd2;
                    upd_target = brpc_lo;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                ctr_q[i]    <= 2'd0;
                target_q[i] <= '0;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            ctr_q[ex_idx]    <= upd_ctr;
            target_q[ex_idx] <= upd_target;
        end
    end

    // SQUASH is the single cycle the redirect pulse is visible; EX holds a wrong-path op then.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mispredict) begin
                        state_q       <= SQUASH;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= actual_taken ? ex_brpc : ex_pc_four;
                    end else begin
                        redirect_q    <= 1'b0;
                        flush_q       <= 1'b0;
                        redirect_pc_q <= 32'd0;
                    end
                end
                default: begin
                    state_q       <= RUN;
                    redirect_q    <= 1'b0;
                    flush_q       <= 1'b0;
                    redirect_pc_q <= 32'd0;
                end
            endcase
        end
    end

    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BP_STATS_EN
    logic [15:0] stat_branches_q;
    logic [15:0] stat_mispredicts_q;
    logic        counted;

    assign counted = resolve && (ex_is_branch || ex_is_jal || ex_is_jalr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_branches_q    <= 16'd0;
            stat_mispredicts_q <= 16'd0;
        end else begin
            if (counted && (stat_branches_q != 16'hFFFF)) begin
                stat_branches_q <= stat_branches_q + 16'd1;
            end
            if (mispredict && (stat_mispredicts_q != 16'hFFFF)) begin
                stat_mispredicts_q <= stat_mispredicts_q + 16'd1;
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, reset-during-squash sequence,
// then randomized traffic checked against a table-level reference model.
module tb_branch_redirect_ctrl;
    logic        clk;
    logic        reset;
    logic [8:0]  if_pc;
    logic        pred_taken;
    logic [8:0]  pred_pc;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [8:0]  ex_pc;
    logic        ex_pred_taken;
    logic [8:0]  ex_pred_pc;
    logic        ex_pcsel;
    logic [31:0] ex_brpc;
    logic [31:0] ex_pc_four;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
`ifdef BP_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    branch_redirect_ctrl #(.PC_W(9), .ENTRIES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_pc       (pred_pc),
        .ex_valid      (ex_valid),
        .ex_is_branch  (ex_is_branch),
        .ex_is_jal     (ex_is_jal),
        .ex_is_jalr    (ex_is_jalr),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_pc    (ex_pred_pc),
        .ex_pcsel      (ex_pcsel),
        .ex_brpc       (ex_brpc),
        .ex_pc_four    (ex_pc_four),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush         (flush)
`ifdef BP_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  ifPc;
        logic        exValid;
        logic        isBr;
        logic        isJal;
        logic        isJalr;
        logic [8:0]  exPc;
        logic        exPredTaken;
        logic [8:0]  exPredPc;
        logic        pcSel;
        logic [31:0] brPc;
        logic        expPredTaken;
        logic [8:0]  expPredPc;
        logic        expRedirect;
        logic [31:0] expRedirectPc;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    int compared   = 0;
    int mismatched = 0;

    bit mValid  [16];
    int mTag    [16];
    int mCtr    [16];
    int mTarget [16];
    bit mSquash;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] ifPcV, input logic exV, input logic isBr,
                                 input logic isJal, input logic isJalr, input logic [8:0] exPcV,
                                 input logic predT, input logic [8:0] predPcV, input logic pcSelV,
                                 input logic [31:0] brPcV);
        if_pc         = ifPcV;
        ex_valid      = exV;
        ex_is_branch  = isBr;
        ex_is_jal     = isJal;
        ex_is_jalr    = isJalr;
        ex_pc         = exPcV;
        ex_pred_taken = predT;
        ex_pred_pc    = predPcV;
        ex_pcsel      = pcSelV;
        ex_brpc       = brPcV;
        ex_pc_four    = 32'(exPcV) + 32'd4;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mValid[i]  = 1'b0;
            mTag[i]    = 0;
            mCtr[i]    = 0;
            mTarget[i] = 0;
        end
        mSquash = 1'b0;
    endtask

    task automatic modelPredict(input int pc, output bit taken, output int target);
        int slot;
        slot   = (pc / 4) % 16;
        taken  = mValid[slot] && (mTag[slot] == pc / 64) && (mCtr[slot] >= 2);
        target = taken ? mTarget[slot] : (pc + 4) % 512;
    endtask

    task automatic modelStep(input bit exV, input bit isBr, input bit isJal, input bit isJalr,
                             input int exPcV, input bit predT, input int predPcV, input bit pcSelV,
                             input logic [31:0] brPcV, output bit expR, output logic [31:0] expRpc);
        int slot;
        int tag;
        int lowTarget;
        bit hit;
        bit wrong;
        expR   = 1'b0;
        expRpc = 32'd0;
        if (mSquash) begin
            mSquash = 1'b0;
            return;
        end
        if (!exV) return;
        lowTarget = int'(brPcV % 512);
        wrong = isJalr || (pcSelV ? (!predT || (predPcV != lowTarget)) : predT);
        if (wrong) begin
            expR    = 1'b1;
            expRpc  = pcSelV ? brPcV : 32'(exPcV + 4);
            mSquash = 1'b1;
        end
        slot = (exPcV / 4) % 16;
        tag  = exPcV / 64;
        hit  = mValid[slot] && (mTag[slot] == tag);
        if (isJalr) begin
        end else if (isJal) begin
            mValid[slot]  = 1'b1;
            mTag[slot]    = tag;
            mCtr[slot]    = 3;
            mTarget[slot] = lowTarget;
        end else if (isBr) begin
            if (hit && pcSelV) begin
                mCtr[slot]    = (mCtr[slot] < 3) ? mCtr[slot] + 1 : 3;
                mTarget[slot] = lowTarget;
            end else if (hit) begin
                mCtr[slot] = (mCtr[slot] > 0) ? mCtr[slot] - 1 : 0;
            end else if (pcSelV) begin
                mValid[slot]  = 1'b1;
                mTag[slot]    = tag;
                mCtr[slot]    = 2;
                mTarget[slot] = lowTarget;
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int pool [8];
        int tgtPool [4];
        int ifP;
        int exP;
        int kind;
        int predPc;
        int pdPc;
        int mP;
        bit pdT;
        bit mT;
        bit exV;
        bit br;
        bit jal;
        bit jalr;
        bit pcS;
        bit predT;
        bit expR;
        logic [31:0] brp;
        logic [31:0] expRpc;

        pool    = '{32'h040, 32'h0A0, 32'h100, 32'h0E4, 32'h1FC, 32'h044, 32'h140, 32'h0A8};
        tgtPool = '{32'h080, 32'h0C0, 32'h100, 32'h1F0};

        vecs[0]  = '{9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h044, 1'b0, 32'h000};
        vecs[1]  = '{9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 1'b0, 9'h044, 1'b1, 32'h080, 1'b0, 9'h044, 1'b1, 32'h080};
        vecs[2]  = '{9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b1, 9'h080, 1'b0, 32'h000};
        vecs[3]  = '{9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 1'b1, 9'h080, 1'b1, 32'h080, 1'b1, 9'h080, 1'b0, 32'h000};
        vecs[4]  = '{9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 1'b1, 9'h080, 1'b0, 32'h080, 1'b1, 9'h080, 1'b1, 32'h044};
        vecs[5]  = '{9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b1, 9'h080, 1'b0, 32'h000};
        vecs[6]  = '{9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 1'b1, 9'h080, 1'b0, 32'h080, 1'b1, 9'h080, 1'b1, 32'h044};
        vecs[7]  = '{9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h044, 1'b0, 32'h000};
        vecs[8]  = '{9'h100, 1'b1, 1'b0, 1'b0, 1'b1, 9'h100, 1'b0, 9'h104, 1'b1, 32'h1F1, 1'b0, 9'h104, 1'b1, 32'h1F1};
        vecs[9]  = '{9'h100, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h104, 1'b0, 32'h000};
        vecs[10] = '{9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h044, 1'b0, 32'h000};
        vecs[11] = '{9'h0A0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0A0, 1'b0, 9'h0A4, 1'b1, 32'h0C0, 1'b0, 9'h0A4, 1'b1, 32'h0C0};
        vecs[12] = '{9'h0A0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0E4, 1'b0, 9'h0E8, 1'b1, 32'h120, 1'b1, 9'h0C0, 1'b0, 32'h000};
        vecs[13] = '{9'h0E4, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h0E8, 1'b0, 32'h000};
        vecs[14] = '{9'h0A0, 1'b1, 1'b0, 1'b1, 1'b0, 9'h0A0, 1'b1, 9'h0C0, 1'b1, 32'h0C0, 1'b1, 9'h0C0, 1'b0, 32'h000};
        vecs[15] = '{9'h0A0, 1'b1, 1'b1, 1'b0, 1'b0, 9'h0A0, 1'b1, 9'h0C0, 1'b1, 32'h0D0, 1'b1, 9'h0C0, 1'b1, 32'h0D0};
        vecs[16] = '{9'h0A0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h000, 1'b1, 9'h0D0, 1'b0, 32'h000};
        vecs[17] = '{9'h1FC, 1'b1, 1'b0, 1'b0, 1'b0, 9'h1FC, 1'b0, 9'h000, 1'b0, 32'h000, 1'b0, 9'h000, 1'b0, 32'h000};

        // Reset state with the fetch PC already at 0x040.
        reset = 1'b0;
        applyStimulus(9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h0);
        #1;
        checkOutput("reset_pred_taken", 32'(pred_taken), 32'h0);
        checkOutput("reset_pred_pc", 32'(pred_pc), 32'h044);
        checkOutput("reset_redirect", 32'(redirect), 32'h0);
        checkOutput("reset_flush", 32'(flush), 32'h0);
        checkOutput("reset_redirect_pc", redirect_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < NVEC; r++) begin
            applyStimulus(vecs[r].ifPc, vecs[r].exValid, vecs[r].isBr, vecs[r].isJal, vecs[r].isJalr,
                          vecs[r].exPc, vecs[r].exPredTaken, vecs[r].exPredPc, vecs[r].pcSel, vecs[r].brPc);
            #1;
            checkOutput($sformatf("vec%0d_pred_taken", r), 32'(pred_taken), 32'(vecs[r].expPredTaken));
            checkOutput($sformatf("vec%0d_pred_pc", r), 32'(pred_pc), 32'(vecs[r].expPredPc));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_redirect", r), 32'(redirect), 32'(vecs[r].expRedirect));
            checkOutput($sformatf("vec%0d_flush", r), 32'(flush), 32'(vecs[r].expRedirect));
            checkOutput($sformatf("vec%0d_redirect_pc", r), redirect_pc, vecs[r].expRedirectPc);
        end

        // Reset arriving while the redirect pulse is up must drop it at once and empty the table.
        applyStimulus(9'h040, 1'b1, 1'b1, 1'b0, 1'b0, 9'h040, 1'b0, 9'h044, 1'b1, 32'h080);
        #1;
        checkOutput("rsq_pre_pred_taken", 32'(pred_taken), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rsq_redirect", 32'(redirect), 32'h1);
        checkOutput("rsq_redirect_pc", redirect_pc, 32'h080);
        applyStimulus(9'h040, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 9'h000, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rsq_async_redirect", 32'(redirect), 32'h0);
        checkOutput("rsq_async_flush", 32'(flush), 32'h0);
        checkOutput("rsq_async_redirect_pc", redirect_pc, 32'h0);
        checkOutput("rsq_async_pred_taken", 32'(pred_taken), 32'h0);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rsq_after_redirect", 32'(redirect), 32'h0);
        checkOutput("rsq_after_pred_taken", 32'(pred_taken), 32'h0);
        checkOutput("rsq_after_pred_pc", 32'(pred_pc), 32'h044);

        modelReset();
        for (int n = 0; n < 400; n++) begin
            ifP  = pool[$urandom_range(0, 7)];
            exP  = pool[$urandom_range(0, 7)];
            exV  = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 9);
            br   = (kind < 5);
            jal  = (kind == 5) || (kind == 6);
            jalr = (kind == 7);
            pcS  = br ? 1'($urandom_range(0, 1)) : (jal || jalr);
            brp  = 32'(tgtPool[$urandom_range(0, 3)]) + (($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'h0);
            modelPredict(exP, pdT, pdPc);
            if ($urandom_range(0, 4) != 0) begin
                predT  = pdT;
                predPc = pdPc;
            end else begin
                predT  = 1'($urandom_range(0, 1));
                predPc = tgtPool[$urandom_range(0, 3)];
            end
            applyStimulus(9'(ifP), exV, br, jal, jalr, 9'(exP), predT, 9'(predPc), pcS, brp);
            #1;
            modelPredict(ifP, mT, mP);
            checkOutput("rnd_pred_taken", 32'(pred_taken), 32'(mT));
            checkOutput("rnd_pred_pc", 32'(pred_pc), 32'(mP));
            modelStep(exV, br, jal, jalr, exP, predT, predPc, pcS, brp, expR, expRpc);
            @(posedge clk);
            #1;
            checkOutput("rnd_redirect", 32'(redirect), 32'(expR));
            checkOutput("rnd_flush", 32'(flush), 32'(expR));
            checkOutput("rnd_redirect_pc", redirect_pc, expRpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
